// File: rtl/lu_fetch_sequencer.sv
// Instruction fetch sequencer for the LU processor: owns the PC and streams codes
// from a synchronous instruction memory onto ICODE, with stall, jump redirect and halt.
module lu_fetch_sequencer #(
    parameter int                AW        = 4,
    parameter int                IW        = 8,
    parameter logic [IW-1:0]     NOP_CODE  = 8'd15,
    parameter logic [IW-1:0]     HALT_CODE = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    input  logic          proc_stall,
    output logic [AW-1:0] imem_addr,
    output logic          imem_re,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] ICODE,
    output logic          icode_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RUN,
        HALTED
    } state_t;

    state_t state;

    assign busy    = (state == FETCH) || (state == RUN);
    assign halted  = (state == HALTED);
    assign imem_re = busy && !proc_stall;

    // imem_addr always runs one word ahead of the word arriving on imem_rdata,
    // so the captured word's address is imem_addr - 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            imem_addr   <= '0;
            ICODE       <= NOP_CODE;
            icode_valid <= 1'b0;
            pc          <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        imem_addr <= start_addr;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!proc_stall) begin
                        imem_addr <= imem_addr + 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (jump) begin
                        ICODE       <= NOP_CODE;
                        icode_valid <= 1'b0;
                        imem_addr   <= jump_addr;
                        state       <= FETCH;
                    end else if (!proc_stall) begin
                        imem_addr <= imem_addr + 1'b1;
                        if (imem_rdata == HALT_CODE) begin
                            ICODE       <= NOP_CODE;
                            icode_valid <= 1'b0;
                            state       <= HALTED;
                        end else begin
                            ICODE       <= imem_rdata;
                            icode_valid <= 1'b1;
                            pc          <= imem_addr - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lu_fetch_sequencer.sv
// Self-checking bench for lu_fetch_sequencer: directed walk-through followed by
// randomized stimulus, all checked against a stream-level reference model.
module tb_lu_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, jump, proc_stall;
    logic [3:0] start_addr, jump_addr, imem_addr, pc;
    logic       imem_re, icode_valid, busy, halted;
    logic [7:0] imem_rdata, ICODE;
    logic [7:0] mem [16];

    int compared   = 0;
    int mismatched = 0;

    // Reference model: 0 idle, 1 streaming, 2 halted; m_primed means a word is in flight
    int         m_state;
    bit         m_primed, m_valid;
    logic [3:0] m_addr, m_pend, m_pc;
    logic [7:0] m_icode;

    always #5 clk = ~clk;

    initial imem_rdata = 8'h00;
    always @(posedge clk) if (imem_re) imem_rdata <= mem[imem_addr];

    lu_fetch_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .jump(jump), .jump_addr(jump_addr), .proc_stall(proc_stall),
        .imem_addr(imem_addr), .imem_re(imem_re), .imem_rdata(imem_rdata),
        .ICODE(ICODE), .icode_valid(icode_valid), .pc(pc),
        .busy(busy), .halted(halted)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit s, input logic [3:0] sa,
                             input bit j, input logic [3:0] ja, input bit st);
        if (r) begin
            m_state = 0; m_addr = 4'd0; m_pc = 4'd0; m_primed = 0;
            m_icode = 8'd15; m_valid = 0;
        end else if (m_state != 1) begin
            if (s) begin
                m_state = 1; m_addr = sa; m_primed = 0;
            end
        end else if (j && m_primed) begin
            m_icode = 8'd15; m_valid = 0; m_addr = ja; m_primed = 0;
        end else if (!st) begin
            if (m_primed && mem[m_pend] == 8'hFF) begin
                m_state = 2; m_icode = 8'd15; m_valid = 0;
            end else begin
                if (m_primed) begin
                    m_icode = mem[m_pend]; m_valid = 1; m_pc = m_pend;
                end
                m_pend   = m_addr;
                m_addr   = m_addr + 4'd1;
                m_primed = 1;
            end
        end
    endtask

    // One clock: drive at negedge, check read enable, clock, then check registered outputs
    task automatic applyStimulus(input bit r, input bit s, input logic [3:0] sa,
                                 input bit j, input logic [3:0] ja, input bit st);
        rst = r; start = s; start_addr = sa; jump = j; jump_addr = ja; proc_stall = st;
        #1;
        checkOutput("imem_re", imem_re, (m_state == 1) && !st);
        @(posedge clk);
        modelStep(r, s, sa, j, ja, st);
        @(negedge clk);
        checkOutput("ICODE", ICODE, m_icode);
        checkOutput("icode_valid", icode_valid, m_valid);
        checkOutput("busy", busy, m_state == 1);
        checkOutput("halted", halted, m_state == 2);
        if (m_valid) checkOutput("pc", pc, m_pc);
        if (m_state == 1 || r) checkOutput("imem_addr", imem_addr, m_addr);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; jump = 1'b0; proc_stall = 1'b0;
        start_addr = 4'd0; jump_addr = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        mem[5] = 8'hFF;
        m_state = 0; m_primed = 0; m_valid = 0; m_addr = 4'd0; m_pend = 4'd0;
        m_pc = 4'd0; m_icode = 8'd15;
        @(negedge clk);

        applyStimulus(1, 1, 4'd7, 0, 0, 0);
        applyStimulus(1, 1, 4'd7, 0, 0, 0);
        checkOutput("rst_icode", ICODE, 8'd15);
        checkOutput("rst_valid", icode_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pc", pc, 0);

        applyStimulus(0, 1, 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        checkOutput("first_word", ICODE, 8'h10);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'd0, 0, 0, 1);
        checkOutput("stall_hold", ICODE, 8'h13);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        checkOutput("stall_release", ICODE, 8'h14);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        checkOutput("halt_icode", ICODE, 8'd15);
        checkOutput("halt_flag", halted, 1);

        applyStimulus(0, 1, 4'd14, 0, 0, 0);
        checkOutput("restart_halted", halted, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 4'd0, 0, 0, 0);
        checkOutput("wrap_word", ICODE, 8'h10);
        checkOutput("wrap_pc", pc, 4'd0);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 1, 4'd9, 0);
        checkOutput("jump_flush", icode_valid, 0);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        checkOutput("jump_target", ICODE, 8'h19);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 0, 0, 1);
        applyStimulus(1, 0, 4'd0, 0, 0, 1);
        checkOutput("midrst_icode", ICODE, 8'd15);
        checkOutput("midrst_busy", busy, 0);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        checkOutput("idle_after_rst", busy, 0);

        for (int n = 0; n < 3000; n++) begin
            if (m_state != 1 && $urandom_range(0, 9) == 0) begin
                for (int i = 0; i < 16; i++)
                    mem[i] = ($urandom_range(0, 11) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            end
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                          4'($urandom_range(0, 15)), $urandom_range(0, 11) == 0,
                          4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
